// File: rtl/crc_seq_pkg.sv
// Shared types and helpers for the CRC frame sequencer: FSM state encoding,
// default CRC-16 constants and the byte-at-a-time CRC update.
package crc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC_HI  = 2'd2,
    CRC_LO  = 2'd3
  } seq_state_t;

  localparam logic [15:0] CRC16_POLY_DEFAULT = 16'h1021;
  localparam logic [15:0] CRC16_INIT_DEFAULT = 16'h0000;

  // The byte enters the low half of the register before the eight shift steps.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data,
                                             input logic [15:0] poly);
    logic [15:0] x;
    x = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      x = x[15] ? ((x << 1) ^ poly) : (x << 1);
    end
    return x;
  endfunction

endpackage

// File: rtl/crc16_engine.sv
// CRC-16 register: folds one byte per enabled cycle, clear returns it to INIT.
module crc16_engine
  import crc_seq_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY_DEFAULT,
  parameter logic [15:0] INIT = CRC16_INIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // Clear wins over enable so a frame end and a stray enable cannot merge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= INIT;
    end else if (clear) begin
      crc <= INIT;
    end else if (en) begin
      crc <= crc16_byte(crc, data, POLY);
    end
  end

endmodule

// File: rtl/crc_frame_sequencer.sv
// Passes payload bytes straight through and appends a 2-byte CRC-16 trailer.
// Define CRC_FRAME_TIMEOUT_EN to build the inter-byte idle timeout.
module crc_frame_sequencer
  import crc_seq_pkg::*;
#(
  parameter logic [15:0] POLY           = CRC16_POLY_DEFAULT,
  parameter logic [15:0] INIT           = CRC16_INIT_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy,
  output logic       timeout_err
);

  seq_state_t  state, state_next;
  logic [15:0] crc;
  logic        pass_phase;
  logic        accept;
  logic        trailer_done;
  logic        abort;

  assign pass_phase   = (state == IDLE) || (state == PAYLOAD);
  // Built from m_ready directly rather than s_ready to keep the comb logic acyclic.
  assign accept       = pass_phase && s_valid && m_ready;
  assign trailer_done = (state == CRC_LO) && m_ready;
  assign busy         = (state != IDLE);

  crc16_engine #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_crc (
    .clk   (clk),
    .reset (reset),
    .clear (trailer_done || abort),
    .en    (accept),
    .data  (s_data),
    .crc   (crc)
  );

`ifdef CRC_FRAME_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_count;
  logic        timeout_pulse;

  // Abort on the edge where the idle count would reach TIMEOUT_CYCLES.
  assign abort = (state == PAYLOAD) && !s_valid && (idle_count == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_count    <= 16'd0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= abort;
      if ((state != PAYLOAD) || s_valid || abort) begin
        idle_count <= 16'd0;
      end else begin
        idle_count <= idle_count + 16'd1;
      end
    end
  end

  assign timeout_err = timeout_pulse;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
  assign abort              = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    m_data     = s_data;
    m_valid    = s_valid;
    m_last     = 1'b0;
    s_ready    = m_ready;
    case (state)
      IDLE, PAYLOAD: begin
        if (accept) begin
          state_next = s_last ? CRC_HI : PAYLOAD;
        end else if (abort) begin
          state_next = IDLE;
        end
      end
      CRC_HI: begin
        s_ready = 1'b0;
        m_valid = 1'b1;
        m_data  = crc[15:8];
        if (m_ready) begin
          state_next = CRC_LO;
        end
      end
      CRC_LO: begin
        s_ready = 1'b0;
        m_valid = 1'b1;
        m_data  = crc[7:0];
        m_last  = 1'b1;
        if (m_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/crc_frame_sequencer.md
CRC_FRAME_SEQUENCER -- requirements
Module: crc_frame_sequencer

Interface
REQ-001 Parameter SHALL be: POLY, 16'h1021, CRC-16 feedback polynomial.
REQ-002 Parameter SHALL be: INIT, 16'h0000, CRC register value at frame start.
REQ-003 Parameter SHALL be: TIMEOUT_CYCLES, 1024, idle-gap limit inside a frame; 16-bit counter, legal range 1..65535.
REQ-004 Port SHALL be: clk  in  1  clock, all state on rising edge.
REQ-005 Port SHALL be: reset  in  1  reset, asynchronous, active-high.
REQ-006 Port SHALL be: s_data / s_valid / s_last  in  8/1/1  upstream payload byte, valid, last-byte-of-frame.
REQ-007 Port SHALL be: s_ready  out  1  upstream byte accepted when s_valid && s_ready.
REQ-008 Port SHALL be: m_data / m_valid / m_last  out  8/1/1  downstream byte, valid, last byte of framed output.
REQ-009 Port SHALL be: m_ready  in  1  downstream accepts when m_valid && m_ready.
REQ-010 Port SHALL be: busy  out  1  high whenever state != IDLE.
REQ-011 Port SHALL be: timeout_err  out  1  one-cycle pulse on frame abort.

Function
REQ-012 FSM SHALL have states IDLE, PAYLOAD, CRC_HI, CRC_LO.
REQ-013 In IDLE and PAYLOAD: m_data = s_data, m_valid = s_valid, m_last = 0, s_ready = m_ready (combinational pass-through, zero latency).
REQ-014 Each accepted byte SHALL update crc on the same edge: crc' = crc XOR {8'h00, data}, then 8 iterations of (bit15 ? (x<<1) XOR POLY : x<<1).
REQ-015 IDLE -> PAYLOAD on accepted byte with s_last = 0; IDLE or PAYLOAD -> CRC_HI on accepted byte with s_last = 1, so single-byte frames are legal.
REQ-016 CRC_HI: s_ready = 0, m_valid = 1, m_data = crc[15:8], m_last = 0; on m_ready -> CRC_LO.
REQ-017 CRC_LO: s_ready = 0, m_valid = 1, m_data = crc[7:0], m_last = 1; on m_ready -> IDLE and crc <= INIT on the same edge.
REQ-018 m_data and m_valid SHALL remain stable in CRC_HI and CRC_LO while m_ready = 0.
REQ-019 The CRC register SHALL never update in CRC_HI or CRC_LO.
REQ-020 m_valid SHALL be 0 in IDLE and PAYLOAD whenever s_valid = 0; no bubble SHALL be inserted between payload and trailer beyond the FSM transition edge.

Reset
REQ-021 On reset: state = IDLE, crc = INIT, timeout counter = 0, timeout_err = 0, busy = 0, m_valid = 0 and m_last = 0 (s_valid permitting), s_ready = m_ready.
REQ-022 Reset asserted mid-frame or mid-trailer SHALL discard the partial frame; no trailer SHALL be emitted after deassertion.

Configuration
REQ-023 Macro CRC_FRAME_TIMEOUT_EN SHALL compile in the inter-byte timeout.
REQ-024 With the macro defined: in PAYLOAD, the counter increments each cycle with s_valid = 0 and clears on any cycle with s_valid = 1.
REQ-025 With the macro defined: at count == TIMEOUT_CYCLES, the block pulses timeout_err for 1 cycle, returns to IDLE, sets crc = INIT and emits no trailer.
REQ-026 With the macro defined: cycles with s_valid = 1 and m_ready = 0 SHALL NOT count, so downstream backpressure never causes a timeout.
REQ-027 Without the macro: no counter is built, timeout_err is tied to 0, and PAYLOAD waits indefinitely.

Structure
REQ-028 Package crc_seq_pkg SHALL hold the state enum typedef, the CRC16_POLY_DEFAULT and CRC16_INIT_DEFAULT constants, and the byte-step CRC function.
REQ-029 Sub-module crc16_engine SHALL hold the CRC register: ports clk, reset, clear, en, data[7:0], crc[15:0].
REQ-030 The FSM, handshake muxing and timeout counter SHALL reside in crc_frame_sequencer.

Verification
REQ-031 Single byte 0x01 with s_last, m_ready = 1 -> output 0x01, 0x01, 0x00; m_last on the third byte; crc = 0x0100.
REQ-032 Frame 0x01, 0x00 -> output 0x01, 0x00, 0x10, 0x21; next frame 0x80 -> trailer 0x80, 0x00, proving re-init.
REQ-033 m_ready low for 5 cycles during CRC_HI -> m_data held at the CRC high byte, s_ready = 0, no CRC change.
REQ-034 Reset pulse after 2 of 4 payload bytes -> busy = 0 next cycle; a following 1-byte frame 0x00 yields trailer 0x00, 0x00.
REQ-035 With CRC_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES = 8: one byte without s_last, then s_valid = 0 for 8 cycles -> timeout_err pulses once, state IDLE, no trailer.
REQ-036 Random s_valid and m_ready over 1000 frames -> each output frame equals its payload followed by the reference-model CRC, with exactly one m_last per frame.
